// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the UART transmit FIFO slice
package uart_pkg;
  localparam int UART_DATA_W     = 8;
  localparam int TIMEOUT_DEFAULT = 64;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with count and full/empty, head visible combinationally
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte queue feeding a UART transmitter, paced by tx_busy
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        count,
  output logic                   overflow,
  output logic                   timeout_err,
  input  logic                   err_clr,
  output logic [UART_DATA_W-1:0] uart_data_in,
  output logic                   uart_transmit_enable,
  input  logic                   uart_tx_busy,
  output logic                   idle
);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       tmo_q, tmo_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic                   en_q, en_d;
  logic                   ovf_q, ovf_d;
  logic                   terr_q, terr_d;
  logic                   pop, tmo_set, ovf_set;
  logic [UART_DATA_W-1:0] head;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (UART_DATA_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (wr_en),
    .pop_i   (pop),
    .wdata_i (wr_data),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    en_d    = en_q;
    pop     = 1'b0;
    tmo_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          data_d  = head;
          en_d    = 1'b1;
          tmo_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (uart_tx_busy) begin
          en_d    = 1'b0;
          tmo_d   = '0;
          state_d = ST_WAIT_DONE;
        end else if (tmo_q == TMO_LAST) begin
          // UART never acknowledged; drop this byte and move on to the next.
          tmo_set = 1'b1;
          en_d    = 1'b0;
          tmo_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!uart_tx_busy) state_d = ST_IDLE;
      end
      default: begin
        en_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // A new error wins over a same-cycle clear.
  assign ovf_set = wr_en && full && !pop;
  assign ovf_d   = ovf_set || (ovf_q && !err_clr);
  assign terr_d  = tmo_set || (terr_q && !err_clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      ovf_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
      terr_q  <= terr_d;
    end
  end

  assign uart_data_in         = data_q;
  assign uart_transmit_enable = en_q;
  assign overflow             = ovf_q;
  assign timeout_err          = terr_q;
  assign idle                 = empty && (state_q == ST_IDLE);
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        err_clr = 1'b0;
  logic        uart_tx_busy;
  logic        full, empty, overflow, timeout_err, idle;
  logic [ADDR_W:0] count;
  logic [7:0]  uart_data_in;
  logic        uart_transmit_enable;

  int n_cmp = 0;
  int n_bad = 0;

  // UART model controls: 0 = normal handshake, 1 = busy stuck high, 2 = busy stuck low
  int uart_mode = 0;
  int u_delay = 2;
  int u_hold  = 20;
  int u_wait = 0;
  int u_hold_cnt = 0;
  int en_len = 0;
  logic en_prev = 1'b0;

  logic [7:0] rx_q[$];
  logic [7:0] sb[$];

  uart_tx_fifo #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .wr_en                (wr_en),
    .wr_data              (wr_data),
    .full                 (full),
    .empty                (empty),
    .count                (count),
    .overflow             (overflow),
    .timeout_err          (timeout_err),
    .err_clr              (err_clr),
    .uart_data_in         (uart_data_in),
    .uart_transmit_enable (uart_transmit_enable),
    .uart_tx_busy         (uart_tx_busy),
    .idle                 (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_pulse_len();
    if (uart_mode == 0) return u_delay + 1;
    if (uart_mode == 1) return 1;
    return TIMEOUT;
  endfunction

  // UART model and monitor, acting 1 time unit after each rising edge
  initial begin
    uart_tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (uart_transmit_enable) begin
        en_len++;
      end else if (en_prev) begin
        check("en_pulse_len", en_len, exp_pulse_len());
        en_len = 0;
      end
      if (uart_transmit_enable && !en_prev) begin
        rx_q.push_back(uart_data_in);
        if (uart_mode == 0) check("busy_low_before_en", int'(uart_tx_busy), 0);
      end
      if (uart_mode != 0) begin
        u_wait = 0;
        u_hold_cnt = 0;
        uart_tx_busy = (uart_mode == 1);
      end else if (uart_transmit_enable && !en_prev) begin
        u_wait = u_delay;
      end else if (u_wait > 0) begin
        u_wait--;
        if (u_wait == 0) begin
          uart_tx_busy = 1'b1;
          u_hold_cnt = u_hold;
        end
      end else if (u_hold_cnt > 0) begin
        u_hold_cnt--;
        if (u_hold_cnt == 0) uart_tx_busy = 1'b0;
      end else begin
        uart_tx_busy = 1'b0;
      end
      en_prev = uart_transmit_enable;
    end
  end

  task automatic push_byte(input logic [7:0] b, input bit accepted);
    wr_en = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
    if (accepted) sb.push_back(b);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!idle && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", int'(idle), 1);
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_len"}, rx_q.size(), sb.size());
    for (int i = 0; i < sb.size() && i < rx_q.size(); i++) check(tag, rx_q[i], sb[i]);
    rx_q.delete();
    sb.delete();
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, ff_seen, got;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_count", count, 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_timeout_err", int'(timeout_err), 0);
    check("rst_data", uart_data_in, 8'h00);
    check("rst_enable", int'(uart_transmit_enable), 0);
    check("rst_idle", int'(idle), 1);

    // Single byte latency
    uart_mode = 0; u_delay = 2; u_hold = 20;
    push_byte(8'hDA, 1'b1);
    check("lat_count_after_push", count, 1);
    check("lat_enable_edge_n", int'(uart_transmit_enable), 0);
    @(negedge clk);
    check("lat_enable_edge_n1", int'(uart_transmit_enable), 1);
    check("lat_data", uart_data_in, 8'hDA);
    check("lat_count_after_pop", count, 0);
    wait_idle(200);
    cmp_stream("single");

    // Back-to-back ordering
    u_delay = 1; u_hold = 3;
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    push_byte(8'h33, 1'b1);
    wait_idle(300);
    cmp_stream("b2b");

    // Fill while UART is busy, then overflow
    uart_mode = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < DEPTH + 1; i++) push_byte(8'($urandom_range(0, 254)), 1'b1);
    check("fill_count", count, DEPTH);
    check("fill_full", int'(full), 1);
    push_byte(8'hFF, 1'b0);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_count", count, DEPTH);
    pulse_err_clr();
    check("ovf_cleared", int'(overflow), 0);

    // Release the UART and push into the full FIFO on the pop cycle
    u_delay = 2; u_hold = 5;
    uart_mode = 0;
    n = 0;
    while (uart_tx_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("busy_released", int'(uart_tx_busy), 0);
    @(negedge clk);
    push_byte(8'hA5, 1'b1);
    check("popfull_count", count, DEPTH);
    check("popfull_overflow", int'(overflow), 0);
    wait_idle(2000);
    ff_seen = 0;
    foreach (rx_q[i]) if (rx_q[i] == 8'hFF) ff_seen++;
    check("ff_never_sent", ff_seen, 0);
    cmp_stream("fill_drain");

    // Handshake timeout, then sequencing continues
    uart_mode = 2;
    repeat (2) @(negedge clk);
    push_byte(8'h55, 1'b1);
    n = 0;
    while (!timeout_err && n < 3 * TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check("tmo_flag", int'(timeout_err), 1);
    @(negedge clk);
    check("tmo_idle", int'(idle), 1);
    uart_mode = 0; u_delay = 1; u_hold = 4;
    @(negedge clk);
    push_byte(8'h66, 1'b1);
    wait_idle(200);
    cmp_stream("tmo_then_next");
    check("tmo_sticky", int'(timeout_err), 1);
    pulse_err_clr();
    check("tmo_cleared", int'(timeout_err), 0);

    // Reset during WAIT_DONE with five bytes queued
    uart_mode = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) push_byte(8'($urandom), 1'b0);
    check("pre_rst_count", count, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", int'(empty), 1);
    check("mid_rst_enable", int'(uart_transmit_enable), 0);
    rx_q.delete();
    sb.delete();
    uart_mode = 0; u_delay = 1; u_hold = 2;
    repeat (40) @(negedge clk);
    got = rx_q.size();
    check("post_rst_no_tx", got, 0);
    check("post_rst_idle", int'(idle), 1);

    // Randomized rounds, never exceeding FIFO capacity
    for (int r = 0; r < 8; r++) begin
      u_delay = $urandom_range(1, 3);
      u_hold  = $urandom_range(1, 8);
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        push_byte(8'($urandom), 1'b1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle(n * 30 + 50);
      cmp_stream("rand");
      check("rand_count", count, 0);
      check("rand_overflow", int'(overflow), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO plus transmit sequencer placed directly upstream of the UART transmitter.
- Producers push bytes at any rate. The block drains the bytes one at a time into the UART's data_in/transmit_enable pair.
- It paces each byte using the UART's tx_busy and flags overflow and handshake timeouts.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- ADDR_W, 4, log2(DEPTH).
- TIMEOUT, 64, max cycles in START waiting for tx_busy to rise; must be >= 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  push wr_data this cycle.
- wr_data  in  8  byte to queue.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  ADDR_W+1  bytes currently queued (excludes the byte in flight).
- overflow  out  1  sticky; a push was rejected.
- timeout_err  out  1  sticky; the UART never raised tx_busy for a byte.
- err_clr  in  1  clears overflow and timeout_err.
- uart_data_in  out  8  to UART data_in; stable from START entry until the next pop.
- uart_transmit_enable  out  1  to UART transmit_enable.
- uart_tx_busy  in  1  from UART tx_busy.
- idle  out  1  empty && state == IDLE.

Behaviour:
- Reset (rst=1 at an edge) forces: state=IDLE, rd/wr pointers=0, count=0, empty=1, full=0, overflow=0, timeout_err=0, uart_data_in=8'h00, uart_transmit_enable=0, idle=1, timeout counter=0. Reset mid-transfer abandons the in-flight byte and all queued bytes.
- Push: wr_en && (!full || pop this cycle) writes wr_data at wr_ptr, and wr_ptr increments modulo DEPTH.
  - wr_en && full && no pop: byte dropped, overflow<=1.
  - If err_clr and a new overflow occur in the same cycle, overflow ends at 1.
- Pop: happens only in IDLE when !empty. The head is copied into the uart_data_in register and rd_ptr increments modulo DEPTH.
- count update: +1 push only, -1 pop only, unchanged when both or neither. Pointers wrap naturally.
- State machine (registered outputs):
  - IDLE: if !empty -> pop, START.
  - START: uart_transmit_enable=1 and the timeout counter increments.
    - If uart_tx_busy=1 -> WAIT_DONE, enable drops to 0 on that transition edge.
    - Else if counter reaches TIMEOUT-1 -> timeout_err<=1, byte discarded, IDLE.
  - WAIT_DONE: enable=0. When uart_tx_busy=0 -> IDLE. No timeout here.
- Latency:
  - Push sampled at edge N into an empty, idle block -> count=1 after N.
  - Pop and START at edge N+1, so uart_transmit_enable is high in cycle N+1.
  - Minimum IDLE gap of 1 cycle between consecutive bytes.
- tx_busy already high on entering START: exits to WAIT_DONE on the next edge (enable high for exactly 1 cycle).
- err_clr alone clears both sticky flags on the next edge. It has no effect on the FIFO or the FSM.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_W=8.
  - State encoding localparams: ST_IDLE=2'd0, ST_START=2'd1, ST_WAIT_DONE=2'd2.
  - TIMEOUT default.
- One natural sub-module: sync_fifo (parameterised DEPTH/width storage, pointers, count, full/empty).
- uart_tx_fifo instantiates sync_fifo and adds the sequencer FSM, timeout counter and sticky flags.

Test Plan:
- Reset, then push 8'hDA at edge N with a UART model raising tx_busy 2 cycles after enable and holding it 20 cycles:
  - uart_transmit_enable high in cycle N+1.
  - uart_data_in=8'hDA.
  - count returns to 0.
  - idle=1 after busy falls.
- Push 8'h11, 8'h22, 8'h33 back to back: UART receives exactly 11,22,33 in order, each enable pulse preceded by tx_busy low, with no duplicates.
- Fill with 16 bytes while uart_tx_busy is held high, then push 8'hFF:
  - full=1, count=16.
  - overflow=1 and 8'hFF is never transmitted.
  - err_clr pulse -> overflow=0.
- uart_tx_busy tied 0, push 8'h55:
  - enable stays high 64 cycles.
  - timeout_err=1, FSM back to IDLE.
  - next pushed byte 8'h66 still presented (sequencing continues).
- Assert rst during WAIT_DONE with 5 bytes queued: next cycle count=0, empty=1, enable=0, and no further bytes emitted.
- Full FIFO, pop and push (8'hA5) in the same cycle: push accepted, count stays 16, overflow=0, and 8'hA5 later transmitted last.
